serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, giving the operand/result width in bits; legal range 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation; sampled only when accepting.
REQ-005 The module SHALL have port sub, input, 1 bit: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The module SHALL have ports a and b, input, WIDTH bits each: operands; sampled with start.
REQ-007 The module SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking result and flags newly valid.
REQ-009 The module SHALL have port result, output, WIDTH bits: registered sum/difference.
REQ-010 The module SHALL have ports cout, ovf and zero, output, 1 bit each: carry out of MSB, signed overflow, result==0.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-012 A request SHALL be accepted when start=1 in IDLE or DONE: latch a, b XOR {WIDTH{sub}}, carry=sub, count=0, then go to SHIFT.
REQ-013 In SHIFT, each cycle SHALL compute s = a0^b0^c and the carry-out; shift s into the result MSB; shift both operands right by one; update carry; increment count.
REQ-014 After the WIDTH-th SHIFT cycle (count==WIDTH-1) the FSM SHALL go to DONE.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE, or to SHIFT if start=1.
REQ-016 busy SHALL equal (state==SHIFT), and done SHALL equal (state==DONE).
REQ-017 Latency: start accepted at edge k SHALL give done=1 during the cycle after edge k+WIDTH, one result per WIDTH+1 cycles back-to-back.
REQ-018 start, a, b and sub SHALL be ignored while busy=1; the in-flight operation is unaffected.
REQ-019 cout SHALL be the final carry out of bit WIDTH-1; for subtraction cout=1 means no borrow (a>=b unsigned).
REQ-020 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB, captured on the last SHIFT cycle.
REQ-021 zero SHALL be 1 if and only if the final result is all zeros.
REQ-022 result, cout, ovf and zero SHALL be updated only on the transition into DONE, and SHALL hold until the next DONE or reset.
REQ-023 The arithmetic SHALL be modulo 2^WIDTH; results wrap silently, with overflow reported only via cout and ovf.

Reset
REQ-024 When reset=1 at a clock edge, the FSM SHALL go to IDLE and result, cout, ovf, zero, busy, done and count SHALL all be 0.
REQ-025 Reset during SHIFT SHALL abandon the operation with no done pulse.
REQ-026 Reset SHALL have priority over a simultaneous start.

Structure
REQ-027 Package serial_addsub_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the WIDTH range constants.
REQ-028 The design SHALL instantiate one sub-module, full_adder_cell (a, b, cin -> s, cout), as the combinational bit slice.
REQ-029 The counter width SHALL be $clog2(WIDTH); no other parameters.

Verification
REQ-030 WIDTH=8: a=0x7F, b=0x01, sub=0 -> after 9 cycles done=1, result=0x80, cout=0, ovf=1, zero=0.
REQ-031 WIDTH=8: a=0x05, b=0x05, sub=1 -> result=0x00, cout=1, ovf=0, zero=1.
REQ-032 WIDTH=8: a=0x03, b=0x05, sub=1 -> result=0xFE, cout=0, ovf=0; and a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
REQ-033 WIDTH=8: start during SHIFT with different operands -> ignored, first result correct; start held in DONE -> next done exactly 9 cycles later.
REQ-034 Reset asserted on the 4th SHIFT cycle -> next cycle IDLE, all outputs 0, no done pulse.
REQ-035 WIDTH=4: a=0xF, b=0x1, sub=0 -> done after 5 cycles, result=0x0, cout=1, zero=1, ovf=0.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_pkg
//  Description : Shared types and constants for the bit-serial adder /
//                subtractor: FSM state encoding and legal WIDTH range.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

    // Legal operand width range for serial_addsub
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : Single-bit full adder used as the combinational slice of
//                the serial adder/subtractor.
//  Ports       : a, b, cin  - addend bits and carry in
//                s, cout    - sum bit and carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial adder/subtractor. One operand bit pair is
//                processed per clock, LSB first; a WIDTH-bit operation
//                takes WIDTH SHIFT cycles followed by one DONE cycle.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                start, sub, a, b  - request, operation select, operands
//                busy, done        - SHIFT in progress, one-cycle result pulse
//                result            - registered sum/difference
//                cout, ovf, zero   - carry out of MSB, signed overflow, result==0
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    // Holds the sum bits produced so far; the newest bit enters at the top
    // so that after WIDTH-1 shifts bit 0 of the sum sits at position 0.
    logic [WIDTH-2:0] r_acc;

    logic             w_accept;
    logic             w_last;
    logic             w_sum;
    logic             w_carry_out;
    logic [WIDTH-1:0] w_acc_next;

    // ------------------------------------------------------------------
    // Bit slice
    // ------------------------------------------------------------------
    full_adder_cell u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_carry_out)
    );

    assign w_acc_next = {w_sum, r_acc};
    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_state == SHIFT) && (r_count == C_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_count == C_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_acc   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_count <= '0;
        end else if (r_state == SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_carry_out;
            r_count <= r_count + 1'b1;
            r_acc   <= w_acc_next[WIDTH-1:1];
            if (w_last) begin
                // r_carry is the carry into the MSB on this final cycle.
                result <= w_acc_next;
                cout   <= w_carry_out;
                ovf    <= r_carry ^ w_carry_out;
                zero   <= (w_acc_next == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Directed self-checking bench for serial_addsub, with one
//                WIDTH=8 instance and one WIDTH=4 instance.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8, zero8;
    logic [7:0] result8;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4, zero4;
    logic [3:0] result4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    // Issue one 8-bit request and wait (bounded) for done; lat counts
    // falling edges after the accepting edge, -1 on timeout.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, output int lat);
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb; sub8 = ts;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done8) lat = -1;
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic ts, output int lat);
        @(negedge clk);
        start4 = 1'b1; a4 = ta; b4 = tb; sub4 = ts;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done4) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, result8, cout8, ovf8, zero8} !== 13'h0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b result=%h cout=%b ovf=%b zero=%b, want all 0",
                     busy8, done8, result8, cout8, ovf8, zero8);
        end
        checks++;
        if ({busy4, done4, result4, cout4, ovf4, zero4} !== 9'h0) begin
            errors++;
            $display("FAIL reset4: got busy=%b done=%b result=%h cout=%b ovf=%b zero=%b, want all 0",
                     busy4, done4, result4, cout4, ovf4, zero4);
        end
        reset = 1'b0;
    endtask

    task automatic test_add_overflow;
        int lat;
        op8(8'h7F, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL add_ovf_latency: got %0d, want 9", lat);
        end
        checks++;
        if ({result8, cout8, ovf8, zero8} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ovf_flags: got result=%h cout=%b ovf=%b zero=%b, want 80 0 1 0",
                     result8, cout8, ovf8, zero8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || result8 !== 8'h80) begin
            errors++;
            $display("FAIL done_pulse_hold: got done=%b result=%h, want done=0 result=80", done8, result8);
        end
    endtask

    task automatic test_sub_cases;
        int lat;
        op8(8'h05, 8'h05, 1'b1, lat);
        checks++;
        if (lat !== 9 || {result8, cout8, ovf8, zero8} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_equal: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 9 00 1 0 1",
                     lat, result8, cout8, ovf8, zero8);
        end
        op8(8'h03, 8'h05, 1'b1, lat);
        checks++;
        if (lat !== 9 || {result8, cout8, ovf8, zero8} !== {8'hFE, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 9 fe 0 0 0",
                     lat, result8, cout8, ovf8, zero8);
        end
        op8(8'h80, 8'h01, 1'b1, lat);
        checks++;
        if (lat !== 9 || {result8, cout8, ovf8, zero8} !== {8'h7F, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_ovf: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 9 7f 1 1 0",
                     lat, result8, cout8, ovf8, zero8);
        end
    endtask

    task automatic test_wrap;
        int lat;
        op8(8'hFF, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== 9 || {result8, cout8, ovf8, zero8} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_ff_plus_1: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 9 00 1 0 1",
                     lat, result8, cout8, ovf8, zero8);
        end
        op8(8'h80, 8'h80, 1'b0, lat);
        checks++;
        if (lat !== 9 || {result8, cout8, ovf8, zero8} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wrap_neg_ovf: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 9 00 1 1 1",
                     lat, result8, cout8, ovf8, zero8);
        end
        op8(8'hA5, 8'h3C, 1'b0, lat);
        checks++;
        if (lat !== 9 || {result8, cout8, ovf8, zero8} !== {8'hE1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_plain: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 9 e1 0 0 0",
                     lat, result8, cout8, ovf8, zero8);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, want 1", busy8);
        end
        lat = 1;
        while (!done8 && lat < 30) begin
            if (lat == 3) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        if (!done8) lat = -1;
        checks++;
        if (lat !== 9 || {result8, cout8, ovf8, zero8} !== {8'h30, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL start_ignored: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 9 30 0 0 0",
                     lat, result8, cout8, ovf8, zero8);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
        @(negedge clk);
        // start stays high; new operands only take effect once DONE accepts.
        a8 = 8'h50; b8 = 8'h60; sub8 = 1'b1;
        lat = 1;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!done8) lat = -1;
        checks++;
        if (lat !== 9 || result8 !== 8'h46) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d result=%h, want 9 46", lat, result8);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checks++;
                if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_reaccept: got busy=%b done=%b, want 1 0", busy8, done8);
                end
                start8 = 1'b0;
            end
        end while (!done8 && lat < 30);
        start8 = 1'b0;
        if (!done8) lat = -1;
        checks++;
        if (lat !== 9 || {result8, cout8, ovf8, zero8} !== {8'hF0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 9 f0 0 0 0",
                     lat, result8, cout8, ovf8, zero8);
        end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        // Fourth SHIFT cycle: assert reset for the coming edge.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy8, done8, result8, cout8, ovf8, zero8} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b result=%h cout=%b ovf=%b zero=%b, want all 0",
                     busy8, done8, result8, cout8, ovf8, zero8);
        end
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", seen_done);
        end
    endtask

    task automatic test_width4;
        int lat;
        op4(4'hF, 4'h1, 1'b0, lat);
        checks++;
        if (lat !== 5 || {result4, cout4, ovf4, zero4} !== {4'h0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL w4_wrap: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 5 0 1 0 1",
                     lat, result4, cout4, ovf4, zero4);
        end
        op4(4'h7, 4'h1, 1'b0, lat);
        checks++;
        if (lat !== 5 || {result4, cout4, ovf4, zero4} !== {4'h8, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL w4_ovf: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 5 8 0 1 0",
                     lat, result4, cout4, ovf4, zero4);
        end
        op4(4'h9, 4'h4, 1'b1, lat);
        checks++;
        if (lat !== 5 || {result4, cout4, ovf4, zero4} !== {4'h5, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL w4_sub: got lat=%0d result=%h cout=%b ovf=%b zero=%b, want 5 5 1 1 0",
                     lat, result4, cout4, ovf4, zero4);
        end
    endtask

    initial begin
        test_reset;
        test_add_overflow;
        test_sub_cases;
        test_wrap;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        test_width4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
